if_fetch_stage: RTL



---
 rtl/if_fetch_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage. Owns the PC, drives a combinational-read
//   instruction memory (byte array, big-endian word read) and loads the
//   IF/ID latch consumed by decode. Decode stalls freeze the PC and IF/ID.
//   A taken branch from EX redirects the PC and puts one bubble in IF/ID.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset_n        synchronous active-low reset
//   stall          hazard stall from decode (hold PC and IF/ID)
//   branch_taken   taken branch/BL resolved in EX (redirect PC)
//   branch_target  byte address of the redirect
//   imem_data      word returned by instruction memory
//   imem_en        instruction memory enable (low only in BOOT)
//   imem_addr      word-aligned fetch address, modulo IMEM_BYTES
//   if_id_instr    latched instruction to decode
//   if_id_pc4      latched PC+4 of that instruction (BL link value)
//   if_id_valid    1 = real instruction, 0 = bubble
//   misalign       one-cycle pulse after a redirect whose target[1:0] != 0
//
// Optional build macro
//   FETCH_PERF_CNT_EN  adds fetch_count / stall_count performance counters.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | single cycle after reset release, no fetch, IF/ID holds bubble
// RUN   | fetching one instruction per cycle
// STALL | decode requested a hold, PC and IF/ID frozen

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 256,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_data,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [31:0] IMEM_SIZE = 32'(IMEM_BYTES);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // pc+4 wraps naturally at 2^32.
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = {pc[31:2], 2'b00} % IMEM_SIZE;
  assign imem_en   = (state != BOOT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      misalign    <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
`endif
    end else begin
      misalign <= 1'b0;
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN, STALL: begin
          // Branch beats stall: the instruction held in decode is on the
          // wrong path anyway, so it is replaced by a bubble.
          if (branch_taken) begin
            pc          <= {branch_target[31:2], 2'b00};
            if_id_instr <= NOP_WORD;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            misalign    <= |branch_target[1:0];
            state       <= RUN;
          end else if (stall) begin
            state <= STALL;
`ifdef FETCH_PERF_CNT_EN
            stall_count <= stall_count + 32'd1;
`endif
          end else begin
            if_id_instr <= imem_data;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            pc          <= pc_plus4;
            state       <= RUN;
`ifdef FETCH_PERF_CNT_EN
            fetch_count <= fetch_count + 32'd1;
`endif
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule
